uart_tx_arbiter: RTL

//  Shares one uart_tx instance among N_REQ byte producers, e.g. console, debug monitor and DMA drain.

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx_arbiter slice.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_t;

  // Number of bits needed to hold the value (at least 1).
  function automatic int unsigned get_width(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches req upward from
// ptr+1, wrapping at N, and returns the winner as one-hot and as index.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] index,
  output logic             any
);

  int unsigned cand;
  logic        found;

  // First set request after ptr, in wrap-around order.
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = |req;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        index        = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N_REQ byte producers.
// Round-robin grant, one-cycle tx_en, waits for tx_ack, pulses done.
// Optional macro UART_ARB_LOCK_EN: an owner holding req_lock keeps the
// transmitter for its next byte without moving the round-robin pointer.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_lock,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    tx_en,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  input  logic                    tx_ack
);

  localparam int unsigned PTR_W = get_width(N_REQ - 1);

  arb_state_t        state, state_n;
  logic [N_REQ-1:0]  grant_n, done_n, sel;
  logic              tx_en_n, frame_end;
  logic [DATA_W-1:0] tx_data_n;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_n;
  logic [N_REQ-1:0]  pick_onehot;
  logic [PTR_W-1:0]  pick_index;
  logic              pick_any;

`ifdef UART_ARB_LOCK_EN
  logic [N_REQ-1:0]  lock_mask, lock_mask_n;
`else
  logic              unused_req_lock;
  assign unused_req_lock = ^req_lock;
`endif

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    done_n    = '0;
    tx_en_n   = 1'b0;
    tx_data_n = tx_data;
    rr_ptr_n  = rr_ptr;
    sel       = '0;
    frame_end = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_mask_n = lock_mask;
`endif
    case (state)
      S_IDLE: begin
        if (pick_any && !tx_busy) begin
`ifdef UART_ARB_LOCK_EN
          if (|(lock_mask & req)) begin
            sel = lock_mask;
          end else begin
            sel      = pick_onehot;
            rr_ptr_n = pick_index;
          end
          lock_mask_n = '0;
`else
          sel      = pick_onehot;
          rr_ptr_n = pick_index;
`endif
          grant_n = sel;
          tx_en_n = 1'b1;
          state_n = S_START;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (sel[i]) tx_data_n = req_data[i*DATA_W +: DATA_W];
          end
        end
      end
      // An ack can beat busy here on a very short frame; close it out directly.
      S_START: begin
        if (tx_ack) frame_end = 1'b1;
        else if (tx_busy) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (tx_ack) frame_end = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    if (frame_end) begin
      done_n  = grant;
      grant_n = '0;
      state_n = S_IDLE;
`ifdef UART_ARB_LOCK_EN
      lock_mask_n = grant & req_lock & req;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      grant   <= '0;
      done    <= '0;
      tx_en   <= 1'b0;
      tx_data <= '0;
      rr_ptr  <= PTR_W'(N_REQ - 1);
`ifdef UART_ARB_LOCK_EN
      lock_mask <= '0;
`endif
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      done    <= done_n;
      tx_en   <= tx_en_n;
      tx_data <= tx_data_n;
      rr_ptr  <= rr_ptr_n;
`ifdef UART_ARB_LOCK_EN
      lock_mask <= lock_mask_n;
`endif
    end
  end

endmodule
